// File: rtl/cw_exp_mq.sv
// cw_exp_mq: per-queue CW exponent and retry tracking with LFSR backoff.
// Optional macro CW_EXP_RETRY_LIMIT_EN adds retry_limit auto-drop.
module cw_exp_mq #(
  parameter int          NUM_QUEUE  = 4,
  parameter int          CW_EXP_MAX = 10,
  parameter int          RETRY_W    = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         QW         = $clog2(NUM_QUEUE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4*NUM_QUEUE-1:0]       cw_exp_min,
  input  logic [4*NUM_QUEUE-1:0]       cw_exp_max,
  input  logic                         tx_try_complete,
  input  logic [QW-1:0]                tx_try_complete_qidx,
  input  logic                         start_retrans,
  input  logic [QW-1:0]                start_retrans_qidx,
`ifdef CW_EXP_RETRY_LIMIT_EN
  input  logic [RETRY_W-1:0]           retry_limit,
`endif
  input  logic                         bo_req,
  input  logic [QW-1:0]                bo_qidx,
  output logic [4*NUM_QUEUE-1:0]       cw_exp,
  output logic [RETRY_W*NUM_QUEUE-1:0] retry_cnt,
  output logic [NUM_QUEUE-1:0]         retry_limit_hit,
  output logic                         bo_valid,
  output logic [15:0]                  bo_value
);

  localparam logic [3:0] CAP = 4'(CW_EXP_MAX);

  for (genvar q = 0; q < NUM_QUEUE; q++) begin : g_q
    logic [3:0]         mx;
    logic [3:0]         mn;
    logic [3:0]         emax;
    logic [3:0]         emin;
    logic [3:0]         cw_q;
    logic [RETRY_W-1:0] rc_q;
    logic               hit_q;
    logic               cmp;
    logic               rtx;
    logic               lim;

    assign mx   = cw_exp_max[4*q +: 4];
    assign mn   = cw_exp_min[4*q +: 4];
    assign emax = (mx > CAP) ? CAP : mx;
    assign emin = (mn > emax) ? emax : mn;

    // Out-of-range indices never match any q, so they are ignored.
    assign cmp = tx_try_complete &&
                 (tx_try_complete_qidx == QW'(q));
    assign rtx = start_retrans &&
                 (start_retrans_qidx == QW'(q));

`ifdef CW_EXP_RETRY_LIMIT_EN
    logic [RETRY_W:0] rc_inc;
    assign rc_inc = {1'b0, rc_q} + (RETRY_W+1)'(1);
    assign lim = (retry_limit != '0) &&
                 (rc_inc >= {1'b0, retry_limit});
`else
    assign lim = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        cw_q  <= emin;
        rc_q  <= '0;
        hit_q <= 1'b0;
      end else begin
        hit_q <= 1'b0;
        if (cmp) begin
          cw_q <= emin;
          rc_q <= '0;
        end else if (rtx) begin
          if (lim) begin
            cw_q  <= emin;
            rc_q  <= '0;
            hit_q <= 1'b1;
          end else begin
            if (cw_q > emax) begin
              cw_q <= emax;
            end else if (cw_q < emax) begin
              cw_q <= cw_q + 4'd1;
            end
            if (rc_q != '1) begin
              rc_q <= rc_q + RETRY_W'(1);
            end
          end
        end
      end
    end

    assign cw_exp[4*q +: 4]          = cw_q;
    assign retry_cnt[RETRY_W*q +: RETRY_W] = rc_q;
`ifdef CW_EXP_RETRY_LIMIT_EN
    assign retry_limit_hit[q] = hit_q;
`else
    assign retry_limit_hit[q] = 1'b0;
`endif
  end

  logic [15:0] lfsr;
  logic        fb;
  logic [3:0]  bo_cw;
  logic        bo_ok;
  logic [15:0] bo_mask;

  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    bo_cw = '0;
    bo_ok = 1'b0;
    for (int q = 0; q < NUM_QUEUE; q++) begin
      if (bo_qidx == QW'(q)) begin
        bo_cw = cw_exp[4*q +: 4];
        bo_ok = 1'b1;
      end
    end
  end

  assign bo_mask = ~(16'hFFFF << bo_cw);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr     <= LFSR_SEED;
      bo_valid <= 1'b0;
      bo_value <= '0;
    end else begin
      lfsr     <= {lfsr[14:0], fb};
      bo_valid <= bo_req;
      if (bo_req) begin
        bo_value <= bo_ok ? (lfsr & bo_mask) : 16'h0;
      end
    end
  end

endmodule

// File: tb/tb_cw_exp_mq.sv
// tb_cw_exp_mq: table vectors plus scoreboarded backoff draws
// against a behavioural model of cw_exp_mq.
module tb_cw_exp_mq;

  localparam int NQ = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cw_exp_min;
  logic [15:0] cw_exp_max;
  logic        tx_try_complete;
  logic [1:0]  tx_try_complete_qidx;
  logic        start_retrans;
  logic [1:0]  start_retrans_qidx;
`ifdef CW_EXP_RETRY_LIMIT_EN
  logic [3:0]  retry_limit;
`endif
  logic        bo_req;
  logic [1:0]  bo_qidx;
  logic [15:0] cw_exp;
  logic [15:0] retry_cnt;
  logic [3:0]  retry_limit_hit;
  logic        bo_valid;
  logic [15:0] bo_value;

  cw_exp_mq dut (
    .clk                  (clk),
    .rst                  (rst),
    .cw_exp_min           (cw_exp_min),
    .cw_exp_max           (cw_exp_max),
    .tx_try_complete      (tx_try_complete),
    .tx_try_complete_qidx (tx_try_complete_qidx),
    .start_retrans        (start_retrans),
    .start_retrans_qidx   (start_retrans_qidx),
`ifdef CW_EXP_RETRY_LIMIT_EN
    .retry_limit          (retry_limit),
`endif
    .bo_req               (bo_req),
    .bo_qidx              (bo_qidx),
    .cw_exp               (cw_exp),
    .retry_cnt            (retry_cnt),
    .retry_limit_hit      (retry_limit_hit),
    .bo_valid             (bo_valid),
    .bo_value             (bo_value)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int          mcw [NQ];
  int          mrc [NQ];
  bit          mhit[NQ];
  logic [15:0] mlfsr;
  logic [15:0] sb[$];
  logic [15:0] last_exp = '0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int f_emax(int q);
    int mx = int'(cw_exp_max[4*q +: 4]);
    return (mx > 10) ? 10 : mx;
  endfunction

  function automatic int f_emin(int q);
    int mn = int'(cw_exp_min[4*q +: 4]);
    int mx = f_emax(q);
    return (mn > mx) ? mx : mn;
  endfunction

  task automatic tick();
    logic [15:0] e;
    logic [15:0] pcw;
    logic [15:0] prc;
    logic [3:0]  phit;
    bit          pushed = 0;
    bit          c;
    bit          r;
    bit          lim;
    if (rst) begin
      for (int q = 0; q < NQ; q++) begin
        mcw[q] = f_emin(q);
        mrc[q] = 0;
        mhit[q] = 0;
      end
      mlfsr = 16'hACE1;
    end else begin
      if (bo_req) begin
        e = mlfsr & 16'((32'd1 << mcw[bo_qidx]) - 1);
        sb.push_back(e);
        last_exp = e;
        pushed = 1;
      end
      for (int q = 0; q < NQ; q++) begin
        mhit[q] = 0;
        c = tx_try_complete && (int'(tx_try_complete_qidx) == q);
        r = start_retrans && (int'(start_retrans_qidx) == q);
`ifdef CW_EXP_RETRY_LIMIT_EN
        lim = (retry_limit != 0) &&
              (mrc[q] + 1 >= int'(retry_limit));
`else
        lim = 0;
`endif
        if (c) begin
          mcw[q] = f_emin(q);
          mrc[q] = 0;
        end else if (r) begin
          if (lim) begin
            mcw[q] = f_emin(q);
            mrc[q] = 0;
            mhit[q] = 1;
          end else begin
            if (mcw[q] > f_emax(q)) mcw[q] = f_emax(q);
            else if (mcw[q] < f_emax(q)) mcw[q]++;
            if (mrc[q] < 15) mrc[q]++;
          end
        end
      end
      mlfsr = {mlfsr[14:0],
               mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    end
    @(posedge clk);
    #1;
    for (int q = 0; q < NQ; q++) begin
      pcw[4*q +: 4] = 4'(mcw[q]);
      prc[4*q +: 4] = 4'(mrc[q]);
      phit[q] = mhit[q];
    end
    chk("cw_exp", 32'(cw_exp), 32'(pcw));
    chk("retry_cnt", 32'(retry_cnt), 32'(prc));
    chk("retry_limit_hit", 32'(retry_limit_hit), 32'(phit));
    if (pushed) begin
      chk("bo_valid_latency", 32'(bo_valid), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bo_value", 32'(bo_value), 32'(e));
      end
    end else begin
      chk("bo_valid_idle", 32'(bo_valid), 32'd0);
    end
  endtask

  typedef struct {
    logic        tc;
    logic [1:0]  tcq;
    logic        rt;
    logic [1:0]  rtq;
    logic [15:0] ecw;
    logic [15:0] erc;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic tc, logic [1:0] tcq,
                              logic rt, logic [1:0] rtq,
                              logic [15:0] ecw,
                              logic [15:0] erc);
    vec_t v;
    v.tc = tc; v.tcq = tcq; v.rt = rt; v.rtq = rtq;
    v.ecw = ecw; v.erc = erc;
    return v;
  endfunction

  task automatic ev(logic tc, logic [1:0] tcq,
                    logic rt, logic [1:0] rtq);
    tx_try_complete = tc;
    tx_try_complete_qidx = tcq;
    start_retrans = rt;
    start_retrans_qidx = rtq;
    tick();
    tx_try_complete = 0;
    start_retrans = 0;
  endtask

  initial begin
    tbl[0]  = mk(0, 0, 1, 1, 16'h4454, 16'h0010);
    tbl[1]  = mk(0, 0, 1, 1, 16'h4464, 16'h0020);
    tbl[2]  = mk(0, 0, 1, 1, 16'h4474, 16'h0030);
    tbl[3]  = mk(0, 0, 1, 1, 16'h4484, 16'h0040);
    tbl[4]  = mk(0, 0, 1, 1, 16'h4494, 16'h0050);
    tbl[5]  = mk(0, 0, 1, 1, 16'h44A4, 16'h0060);
    tbl[6]  = mk(0, 0, 1, 1, 16'h44A4, 16'h0070);
    tbl[7]  = mk(0, 0, 1, 1, 16'h44A4, 16'h0080);
    tbl[8]  = mk(1, 1, 0, 0, 16'h4444, 16'h0000);
    tbl[9]  = mk(0, 0, 1, 2, 16'h4544, 16'h0100);
    tbl[10] = mk(0, 0, 1, 2, 16'h4644, 16'h0200);
    tbl[11] = mk(0, 0, 1, 2, 16'h4744, 16'h0300);
    tbl[12] = mk(1, 2, 1, 2, 16'h4444, 16'h0000);
    tbl[13] = mk(0, 0, 1, 3, 16'h5444, 16'h1000);
    tbl[14] = mk(0, 0, 1, 0, 16'h5445, 16'h1001);
    tbl[15] = mk(1, 0, 1, 3, 16'h6444, 16'h2000);

    rst = 1;
    cw_exp_min = 16'h4444;
    cw_exp_max = 16'hAAAA;
    tx_try_complete = 0;
    tx_try_complete_qidx = 0;
    start_retrans = 0;
    start_retrans_qidx = 0;
`ifdef CW_EXP_RETRY_LIMIT_EN
    retry_limit = 0;
`endif
    bo_req = 0;
    bo_qidx = 0;
    repeat (3) tick();
    chk("rst_cw", 32'(cw_exp), 32'h4444);
    chk("rst_rc", 32'(retry_cnt), 32'h0);
    chk("rst_bo_valid", 32'(bo_valid), 32'h0);

    rst = 0;
    bo_req = 1;
    bo_qidx = 0;
    tick();
    chk("first_draw", 32'(bo_value), 32'h0001);
    bo_req = 0;

    for (int i = 0; i < 16; i++) begin
      ev(tbl[i].tc, tbl[i].tcq, tbl[i].rt, tbl[i].rtq);
      chk($sformatf("tbl%0d_cw", i), 32'(cw_exp),
          32'(tbl[i].ecw));
      chk($sformatf("tbl%0d_rc", i), 32'(retry_cnt),
          32'(tbl[i].erc));
    end

    ev(1, 1, 0, 0);
    ev(0, 0, 1, 1);
    chk("q1_cw5", 32'(cw_exp[7:4]), 32'd5);
    for (int i = 0; i < 1000; i++) begin
      bo_req = 1;
      bo_qidx = 1;
      tick();
      chk("bo_range", 32'(bo_value <= 16'd31), 32'd1);
    end
    for (int i = 0; i < 200; i++) begin
      bo_req = 1'($urandom_range(0, 1));
      bo_qidx = 2'($urandom_range(0, 3));
      tick();
    end
    bo_req = 0;
    tick();
    tick();
    chk("bo_hold", 32'(bo_value), 32'(last_exp));

    repeat (5) ev(0, 0, 1, 1);
    chk("q1_at_max", 32'(cw_exp[7:4]), 32'd10);
    cw_exp_max[7:4] = 4'd6;
    ev(0, 0, 1, 1);
    chk("clamp_max", 32'(cw_exp[7:4]), 32'd6);
    cw_exp_min[7:4] = 4'd9;
    ev(1, 1, 0, 0);
    chk("min_over_max", 32'(cw_exp[7:4]), 32'd6);
    cw_exp_min = 16'h4444;
    cw_exp_max = 16'hAAAA;
    ev(1, 1, 0, 0);

    ev(1, 0, 0, 0);
`ifdef CW_EXP_RETRY_LIMIT_EN
    retry_limit = 4'd3;
`endif
    repeat (3) ev(0, 0, 1, 0);
`ifdef CW_EXP_RETRY_LIMIT_EN
    chk("lim_hit", 32'(retry_limit_hit[0]), 32'd1);
    chk("lim_cw", 32'(cw_exp[3:0]), 32'd4);
    chk("lim_rc", 32'(retry_cnt[3:0]), 32'd0);
`else
    chk("nolim_hit", 32'(retry_limit_hit[0]), 32'd0);
    chk("nolim_cw", 32'(cw_exp[3:0]), 32'd7);
    chk("nolim_rc", 32'(retry_cnt[3:0]), 32'd3);
`endif
    tick();
    chk("hit_one_cycle", 32'(retry_limit_hit), 32'd0);
`ifdef CW_EXP_RETRY_LIMIT_EN
    retry_limit = 4'd0;
`endif
    ev(1, 0, 0, 0);
    repeat (17) ev(0, 0, 1, 0);
    chk("rc_saturate", 32'(retry_cnt[3:0]), 32'hF);
    chk("cw_sat_max", 32'(cw_exp[3:0]), 32'd10);

    bo_req = 1;
    bo_qidx = 0;
    rst = 1;
    tick();
    chk("rst_drops_req", 32'(bo_valid), 32'd0);
    rst = 0;
    bo_req = 0;
    tick();
    chk("rst_mid_cw", 32'(cw_exp), 32'h4444);
    chk("rst_mid_rc", 32'(retry_cnt), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
